config_chain_loader: RTL and testbench

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

---
 rtl/config_chain_loader.sv | 146 ++++++++++++++
 tb/tb_config_chain_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// Serial configuration-chain loader: clears the chain, then shifts host words in LSB-first.
// Optional build macro CFG_READBACK_EN adds a readback collector on cfg_return (rb_word/rb_valid).
module config_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [WORD-1:0] word_in,
    input  logic            word_valid,
    output logic            word_ready,
    output logic            cfg_reset,
    output logic            cfg_shift,
    output logic            cfg_data,
    input  logic            cfg_return,
    output logic            busy,
    output logic            done
`ifdef CFG_READBACK_EN
    ,
    output logic [WORD-1:0] rb_word,
    output logic            rb_valid
`endif
);

    localparam int RW = $clog2(CHAIN_LEN + 1);
    localparam int BW = $clog2(WORD + 1);
    localparam logic [RW-1:0] R_ONE  = RW'(1);
    localparam logic [RW-1:0] R_FULL = RW'(CHAIN_LEN);
    localparam logic [BW-1:0] B_ONE  = BW'(1);
    localparam logic [BW-1:0] B_FULL = BW'(WORD);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHIFT, DONE} state_t;

    state_t          state;
    logic [RW-1:0]   remaining;
    logic [BW-1:0]   bits_left;
    logic [WORD-1:0] shift_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            remaining  <= '0;
            bits_left  <= '0;
            shift_reg  <= '0;
            word_ready <= 1'b0;
            cfg_reset  <= 1'b0;
            cfg_shift  <= 1'b0;
            cfg_data   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            cfg_reset <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        cfg_reset <= 1'b1;
                    end
                end
                CLEAR: begin
                    state      <= LOAD;
                    remaining  <= R_FULL;
                    word_ready <= 1'b1;
                end
                LOAD: begin
                    if (word_valid && word_ready) begin
                        state      <= SHIFT;
                        word_ready <= 1'b0;
                        shift_reg  <= word_in;
                        bits_left  <= B_FULL;
                        cfg_shift  <= 1'b1;
                        cfg_data   <= word_in[0];
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    bits_left <= bits_left - B_ONE;
                    if (remaining != '0)
                        remaining <= remaining - R_ONE;
                    // Chain end takes priority over word end so a partial last word is cut short.
                    if (remaining <= R_ONE) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        cfg_shift <= 1'b0;
                        cfg_data  <= 1'b0;
                    end else if (bits_left == B_ONE) begin
                        state      <= LOAD;
                        word_ready <= 1'b1;
                        cfg_shift  <= 1'b0;
                        cfg_data   <= 1'b0;
                    end else begin
                        cfg_data <= shift_reg[1];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CFG_READBACK_EN
    logic [WORD-1:0] rb_col;
    logic [WORD-1:0] rb_next;
    logic [BW-1:0]   rb_cnt;

    always_comb begin
        rb_next = rb_col | ({{(WORD-1){1'b0}}, cfg_return} << rb_cnt);
    end

    // cfg_return is sampled on the same edge the chain shifts, i.e. the bit leaving the far end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rb_col   <= '0;
            rb_cnt   <= '0;
            rb_word  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (state == CLEAR) begin
                rb_col <= '0;
                rb_cnt <= '0;
            end else if (cfg_shift) begin
                if (rb_cnt == B_FULL - B_ONE || remaining == R_ONE) begin
                    rb_word  <= rb_next;
                    rb_valid <= 1'b1;
                    rb_col   <= '0;
                    rb_cnt   <= '0;
                end else begin
                    rb_col <= rb_next;
                    rb_cnt <= rb_cnt + B_ONE;
                end
            end
        end
    end
`else
    logic unused_cfg_return;
    assign unused_cfg_return = cfg_return;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: 64/32 instance with a chain model, 40/32 instance for partial words.
module tb_config_chain_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        a_start = 0, a_valid = 0;
    logic [31:0] a_word = '0;
    logic        a_ready, a_clr, a_shift, a_data, a_busy, a_done, a_ret;
    logic        b_start = 0, b_valid = 0;
    logic [31:0] b_word = '0;
    logic        b_ready, b_clr, b_shift, b_data, b_busy, b_done;
`ifdef CFG_READBACK_EN
    logic [31:0] a_rb_word, b_rb_word;
    logic        a_rb_valid, b_rb_valid;
`endif

    config_chain_loader #(.CHAIN_LEN(64), .WORD(32)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .word_in(a_word), .word_valid(a_valid),
        .word_ready(a_ready), .cfg_reset(a_clr), .cfg_shift(a_shift), .cfg_data(a_data),
        .cfg_return(a_ret), .busy(a_busy), .done(a_done)
`ifdef CFG_READBACK_EN
        , .rb_word(a_rb_word), .rb_valid(a_rb_valid)
`endif
    );

    config_chain_loader #(.CHAIN_LEN(40), .WORD(32)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .word_in(b_word), .word_valid(b_valid),
        .word_ready(b_ready), .cfg_reset(b_clr), .cfg_shift(b_shift), .cfg_data(b_data),
        .cfg_return(1'b0), .busy(b_busy), .done(b_done)
`ifdef CFG_READBACK_EN
        , .rb_word(b_rb_word), .rb_valid(b_rb_valid)
`endif
    );

    // Downstream chain model for instance A; config_in enters at the top, config_out leaves bit 0.
    logic [63:0] chain_a = '0;
    always @(posedge clk) if (a_shift) chain_a <= {a_data, chain_a[63:1]};
    assign a_ret = chain_a[0];

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          a_n, a_busy_n, a_done_n, a_done_at, a_clr_n, zero_err;
    int          b_n, b_busy_n, b_done_n, b_done_at;
    logic [63:0] a_col, b_col;
    logic [31:0] rb_q[$];

    always @(negedge clk) begin
        if (a_busy) a_busy_n++;
        if (a_done) begin a_done_n++; a_done_at = a_busy_n; end
        if (a_clr) a_clr_n++;
        if (a_shift) begin if (a_n < 64) a_col[a_n] = a_data; a_n++; end
        else if (a_data) zero_err++;
        if (b_busy) b_busy_n++;
        if (b_done) begin b_done_n++; b_done_at = b_busy_n; end
        if (b_shift) begin if (b_n < 64) b_col[b_n] = b_data; b_n++; end
        else if (b_data) zero_err++;
`ifdef CFG_READBACK_EN
        if (a_rb_valid) rb_q.push_back(a_rb_word);
`endif
    end

    task automatic wait_ready(input bit sel, output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sel ? b_ready : a_ready) === 1'b1) begin ok = 1; break; end
        end
        if (!ok) check(sel ? "b_ready_timeout" : "a_ready_timeout", 0, 1);
    endtask

    task automatic wait_idle(input bit sel);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sel ? b_busy : a_busy) === 1'b0) break;
        end
        check(sel ? "b_idle" : "a_idle", sel ? b_busy : a_busy, 0);
    endtask

    task automatic load_a(input logic [31:0] w0, input logic [31:0] w1, input int stall,
                          input bit poke_start);
        bit ok;
        bit stall_ok;
        a_n = 0; a_busy_n = 0; a_done_n = 0; a_done_at = 0; a_clr_n = 0; a_col = '0;
        rb_q.delete();
        @(negedge clk) a_start = 1;
        @(negedge clk) a_start = 0;
        if (stall > 0) begin
            wait_ready(0, ok);
            stall_ok = 1;
            for (int i = 0; i < stall; i++) begin
                if (a_ready !== 1'b1 || a_shift !== 1'b0) stall_ok = 0;
                @(negedge clk);
            end
            check("stall_hold", {63'd0, stall_ok}, 1);
            a_valid = 1; a_word = w0;
        end else begin
            a_valid = 1; a_word = w0;
            wait_ready(0, ok);
        end
        @(negedge clk) a_word = w1;
        if (poke_start) begin
            @(negedge clk) a_start = 1;
            @(negedge clk) a_start = 0;
        end
        wait_ready(0, ok);
        @(negedge clk) a_valid = 0;
        wait_idle(0);
    endtask

    initial begin
        bit ok;
        #1;
        check("rst_outputs", {a_ready, a_clr, a_shift, a_data, a_busy, a_done}, 0);
`ifdef CFG_READBACK_EN
        check("rst_rb", {a_rb_word, a_rb_valid}, 0);
`endif
        @(negedge clk) reset = 1;

        // Abort a load mid-shift with an asynchronous reset.
        @(negedge clk) a_start = 1;
        @(negedge clk) begin a_start = 0; a_valid = 1; a_word = 32'hFFFF_FFFF; end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_shift) break;
        end
        repeat (3) @(negedge clk);
        check("pre_abort_shift", {a_shift, a_data, a_busy}, 3'b111);
        #2 reset = 0;
        #1 check("abort_outputs", {a_ready, a_clr, a_shift, a_data, a_busy, a_done}, 0);
        @(negedge clk) check("abort_idle", {a_ready, a_shift, a_busy}, 0);
        a_valid = 0;
        reset = 1;

        // Full two-word load after the abort.
        load_a(32'hA5A5_A5A5, 32'h0000_FFFF, 0, 0);
        check("two_shifts", a_n, 64);
        check("two_bits", a_col, 64'h0000_FFFF_A5A5_A5A5);
        check("two_first_byte", a_col[7:0], 8'hA5);
        check("two_busy_cycles", a_busy_n, 68);
        check("two_done_at", a_done_at, 68);
        check("two_done_count", a_done_n, 1);
        check("two_clr_count", a_clr_n, 1);

        // Host stalls 10 cycles before the first word; this also preloads the chain.
        load_a(32'h9ABC_DEF0, 32'h1234_5678, 10, 0);
        check("stall_shifts", a_n, 64);
        check("stall_bits", a_col, 64'h1234_5678_9ABC_DEF0);
        check("stall_busy_cycles", a_busy_n, 78);

        // Start pulsed during SHIFT must be ignored.
        load_a(32'hDEAD_BEEF, 32'h0123_4567, 0, 1);
        check("ign_done_count", a_done_n, 1);
        check("ign_clr_count", a_clr_n, 1);
        check("ign_busy_cycles", a_busy_n, 68);
        check("ign_bits", a_col, 64'h0123_4567_DEAD_BEEF);
`ifdef CFG_READBACK_EN
        check("rb_count", rb_q.size(), 2);
        check("rb_word0", rb_q.size() > 0 ? rb_q[0] : 32'hX, 32'h9ABC_DEF0);
        check("rb_word1", rb_q.size() > 1 ? rb_q[1] : 32'hX, 32'h1234_5678);
`endif

        // 40-bit chain: only the low 8 bits of the second word go out.
        b_n = 0; b_busy_n = 0; b_done_n = 0; b_done_at = 0; b_col = '0;
        @(negedge clk) b_start = 1;
        @(negedge clk) begin b_start = 0; b_valid = 1; b_word = 32'hCAFE_F00D; end
        wait_ready(1, ok);
        @(negedge clk) b_word = 32'hFFFF_FF12;
        wait_ready(1, ok);
        @(negedge clk) b_valid = 0;
        wait_idle(1);
        check("part_shifts", b_n, 40);
        check("part_bits", b_col, 64'h0000_0012_CAFE_F00D);
        check("part_busy_cycles", b_busy_n, 44);
        check("part_done_at", b_done_at, 44);
        check("part_done_count", b_done_n, 1);

        check("data_zero_when_idle", zero_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
